// File: rtl/pl_fetch_queue.sv
// ---------------------------------------------------------------------------
// pl_fetch_queue
//   Instruction prefetch queue sitting between instruction memory and the
//   Decode pipeline wall. It owns the fetch PC and keeps fetching into a small
//   circular buffer while Decode is stalled. The oldest buffered
//   {inst, pc, pc+4} is presented combinationally to Decode. A redirect from
//   Execute flushes the buffer and restarts fetch at the redirect target.
//
// Parameters
//   XLEN      width of pc, pc+4 and redirect target
//   DEPTH     number of queue entries (power of two, >= 2)
//   PC_RESET  fetch PC after reset
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   redirect      Execute redirect, flushes the queue (highest priority)
//   redirect_pc   new fetch target, sampled when redirect=1
//   imem_addr     byte address presented to instruction memory (= fetch PC)
//   imem_inst     combinational instruction memory data for imem_addr
//   deq_stall     Decode stall; head entry is held when 1
//   deq_valid     head entry is valid
//   deq_inst      head instruction (0 when empty)
//   deq_pc        head pc (0 when empty)
//   deq_pc_plus4  head pc + 4 as stored at fetch time (0 when empty)
//   count         number of occupied entries, 0..DEPTH
// ---------------------------------------------------------------------------
module pl_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] PC_RESET = {XLEN{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic [XLEN-1:0]          imem_addr,
    input  logic [31:0]              imem_inst,
    input  logic                     deq_stall,
    output logic                     deq_valid,
    output logic [31:0]              deq_inst,
    output logic [XLEN-1:0]          deq_pc,
    output logic [XLEN-1:0]          deq_pc_plus4,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(4'd4);

    // Queue state
    logic [XLEN-1:0]  r_fetch_pc;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    // Entry storage; contents beyond the occupied window are don't-care,
    // so the array carries no reset.
    logic [31:0]      r_mem_inst [DEPTH];
    logic [XLEN-1:0]  r_mem_pc   [DEPTH];
    logic [XLEN-1:0]  r_mem_pc4  [DEPTH];

    logic             w_valid;
    logic             w_full;
    logic             w_deq;
    logic             w_enq;
    logic [XLEN-1:0]  w_pc_plus4;

    assign w_valid    = (r_count != CNT_ZERO);
    assign w_full     = (r_count == CNT_FULL);
    assign w_pc_plus4 = r_fetch_pc + PC_STEP;

    // Redirect suppresses both sides; a full queue still enqueues when the
    // head leaves in the same cycle, so steady-state streaming never bubbles.
    assign w_deq = w_valid & ~deq_stall & ~redirect;
    assign w_enq = ~redirect & (~w_full | w_deq);

    // Fetch PC, pointers and occupancy; redirect overrides everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= PC_RESET;
            r_rd_ptr   <= PTR_ZERO;
            r_wr_ptr   <= PTR_ZERO;
            r_count    <= CNT_ZERO;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc;
            r_rd_ptr   <= PTR_ZERO;
            r_wr_ptr   <= PTR_ZERO;
            r_count    <= CNT_ZERO;
        end else begin
            if (w_enq) begin
                r_fetch_pc <= w_pc_plus4;
                r_wr_ptr   <= r_wr_ptr + PTR_ONE;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry write: capture the word fetched at the current PC with its pc/pc+4
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem_inst[r_wr_ptr] <= imem_inst;
            r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
            r_mem_pc4[r_wr_ptr]  <= w_pc_plus4;
        end
    end

    assign imem_addr = r_fetch_pc;
    assign deq_valid = w_valid;
    assign count     = r_count;

    // Head presentation; fields read as zero while the queue is empty
    always_comb begin
        deq_inst     = 32'd0;
        deq_pc       = {XLEN{1'b0}};
        deq_pc_plus4 = {XLEN{1'b0}};
        if (w_valid) begin
            deq_inst     = r_mem_inst[r_rd_ptr];
            deq_pc       = r_mem_pc[r_rd_ptr];
            deq_pc_plus4 = r_mem_pc4[r_rd_ptr];
        end else begin
            deq_inst     = 32'd0;
            deq_pc       = {XLEN{1'b0}};
            deq_pc_plus4 = {XLEN{1'b0}};
        end
    end

endmodule

// File: tb/tb_pl_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_pl_fetch_queue
//   Drives three queue instances (DEPTH 2, 4, 8) with common control inputs.
//   Each instance has its own combinational instruction memory model.
//   The reference model exploits the fact that buffered pcs are always
//   consecutive words: the queue is fully described by its head pc and its
//   occupancy. The fetch pc is head + 4*occupancy.
// ---------------------------------------------------------------------------
module tb_pl_fetch_queue;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq_stall;

    logic [31:0] w_addr  [3];
    logic [31:0] w_inst  [3];
    logic        w_valid [3];
    logic [31:0] w_dinst [3];
    logic [31:0] w_dpc   [3];
    logic [31:0] w_dpc4  [3];
    logic [3:0]  w_cnt   [3];
    logic [1:0]  w_cnt2;
    logic [2:0]  w_cnt4;
    logic [3:0]  w_cnt8;

    int          checks;
    int          errors;

    logic [31:0] m_head [3];
    int          m_cnt  [3];
    int          dep    [3];
    logic [31:0] pcr    [3];

    // Instruction memory contents as a function of the byte address
    function automatic logic [31:0] imem_f(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A0F};
    endfunction

    assign w_inst[0] = imem_f(w_addr[0]);
    assign w_inst[1] = imem_f(w_addr[1]);
    assign w_inst[2] = imem_f(w_addr[2]);
    assign w_cnt[0]  = {2'b00, w_cnt2};
    assign w_cnt[1]  = {1'b0, w_cnt4};
    assign w_cnt[2]  = w_cnt8;

    pl_fetch_queue #(.XLEN(32), .DEPTH(2), .PC_RESET(32'h0000_0000)) u_dut2 (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_addr(w_addr[0]), .imem_inst(w_inst[0]), .deq_stall(deq_stall),
        .deq_valid(w_valid[0]), .deq_inst(w_dinst[0]), .deq_pc(w_dpc[0]),
        .deq_pc_plus4(w_dpc4[0]), .count(w_cnt2));

    pl_fetch_queue #(.XLEN(32), .DEPTH(4), .PC_RESET(32'h0000_0000)) u_dut4 (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_addr(w_addr[1]), .imem_inst(w_inst[1]), .deq_stall(deq_stall),
        .deq_valid(w_valid[1]), .deq_inst(w_dinst[1]), .deq_pc(w_dpc[1]),
        .deq_pc_plus4(w_dpc4[1]), .count(w_cnt4));

    pl_fetch_queue #(.XLEN(32), .DEPTH(8), .PC_RESET(32'h0000_1000)) u_dut8 (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_addr(w_addr[2]), .imem_inst(w_inst[2]), .deq_stall(deq_stall),
        .deq_valid(w_valid[2]), .deq_inst(w_dinst[2]), .deq_pc(w_dpc[2]),
        .deq_pc_plus4(w_dpc4[2]), .count(w_cnt8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected head fields and fetch address from the model
    function automatic logic [31:0] exp_pc(input int k);
        return (m_cnt[k] > 0) ? m_head[k] : 32'd0;
    endfunction
    function automatic logic [31:0] exp_pc4(input int k);
        return (m_cnt[k] > 0) ? m_head[k] + 32'd4 : 32'd0;
    endfunction
    function automatic logic [31:0] exp_inst(input int k);
        return (m_cnt[k] > 0) ? imem_f(m_head[k]) : 32'd0;
    endfunction
    function automatic logic [31:0] exp_addr(input int k);
        return m_head[k] + 32'(4 * m_cnt[k]);
    endfunction

    // Advance one clock edge and move the model accordingly
    task automatic tick();
        logic [31:0] nh [3];
        int          nc [3];
        for (int k = 0; k < 3; k++) begin
            logic d;
            logic e;
            d = (m_cnt[k] > 0) && !deq_stall && !redirect;
            e = !redirect && ((m_cnt[k] < dep[k]) || d);
            if (redirect) begin
                nh[k] = redirect_pc;
                nc[k] = 0;
            end else begin
                nh[k] = d ? m_head[k] + 32'd4 : m_head[k];
                nc[k] = m_cnt[k] + (e ? 1 : 0) - (d ? 1 : 0);
            end
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            m_head[k] = nh[k];
            m_cnt[k]  = nc[k];
        end
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_head[k] = pcr[k];
            m_cnt[k]  = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (w_valid[k] !== 1'b0 || w_cnt[k] !== 4'd0) begin
                errors++;
                $display("FAIL reset_valid_count dut%0d got valid=%0b count=%0d want 0/0", k, w_valid[k], w_cnt[k]);
            end
            checks++;
            if (w_addr[k] !== pcr[k]) begin
                errors++;
                $display("FAIL reset_addr dut%0d got %h want %h", k, w_addr[k], pcr[k]);
            end
            checks++;
            if (w_dpc[k] !== 32'd0 || w_dpc4[k] !== 32'd0 || w_dinst[k] !== 32'd0) begin
                errors++;
                $display("FAIL reset_head_zero dut%0d got pc=%h pc4=%h inst=%h want 0", k, w_dpc[k], w_dpc4[k], w_dinst[k]);
            end
        end
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_stream(input int n);
        deq_stall = 1'b0;
        redirect  = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (w_valid[k] !== (m_cnt[k] > 0) || w_cnt[k] !== 4'(m_cnt[k])) begin
                    errors++;
                    $display("FAIL stream_count dut%0d cyc%0d got v=%0b c=%0d want v=%0b c=%0d",
                             k, i, w_valid[k], w_cnt[k], m_cnt[k] > 0, m_cnt[k]);
                end
                checks++;
                if (w_dpc[k] !== exp_pc(k) || w_dpc4[k] !== exp_pc4(k) || w_dinst[k] !== exp_inst(k)) begin
                    errors++;
                    $display("FAIL stream_head dut%0d cyc%0d got pc=%h pc4=%h inst=%h want %h %h %h",
                             k, i, w_dpc[k], w_dpc4[k], w_dinst[k], exp_pc(k), exp_pc4(k), exp_inst(k));
                end
                checks++;
                if (w_addr[k] !== exp_addr(k)) begin
                    errors++;
                    $display("FAIL stream_addr dut%0d cyc%0d got %h want %h", k, i, w_addr[k], exp_addr(k));
                end
            end
            // Streaming from reset at PC 0: one entry, pc advances by one word per cycle
            checks++;
            if (w_cnt[1] !== 4'd1 || w_dpc[1] !== 32'(4 * i)) begin
                errors++;
                $display("FAIL stream_seq cyc%0d got count=%0d pc=%h want 1 %h", i, w_cnt[1], w_dpc[1], 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        deq_stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (w_cnt[k] !== 4'(m_cnt[k]) || w_addr[k] !== exp_addr(k) || w_dpc[k] !== exp_pc(k)) begin
                    errors++;
                    $display("FAIL stall_state dut%0d cyc%0d got c=%0d a=%h pc=%h want %0d %h %h",
                             k, i, w_cnt[k], w_addr[k], w_dpc[k], m_cnt[k], exp_addr(k), exp_pc(k));
                end
            end
        end
        checks++;
        if (w_cnt[1] !== 4'd4 || w_addr[1] !== 32'h10 || w_dpc[1] !== 32'h0) begin
            errors++;
            $display("FAIL stall_full got count=%0d addr=%h pc=%h want 4 00000010 00000000", w_cnt[1], w_addr[1], w_dpc[1]);
        end
        deq_stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (w_valid[1] !== 1'b1 || w_dpc[1] !== 32'(4 * i)) begin
                errors++;
                $display("FAIL stall_release idx%0d got v=%0b pc=%h want 1 %h", i, w_valid[1], w_dpc[1], 32'(4 * i));
            end
            tick();
        end
    endtask

    task automatic test_full_deq();
        logic [31:0] a0;
        deq_stall = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        for (int i = 0; i < 6; i++) begin
            a0 = w_addr[1];
            deq_stall = 1'b0;
            tick();
            deq_stall = 1'b1;
            checks++;
            if (w_cnt[1] !== 4'd4 || w_addr[1] !== a0 + 32'd4) begin
                errors++;
                $display("FAIL full_deq step%0d got count=%0d addr=%h want 4 %h", i, w_cnt[1], w_addr[1], a0 + 32'd4);
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (w_dpc[k] !== exp_pc(k) || w_dinst[k] !== exp_inst(k) || w_cnt[k] !== 4'(m_cnt[k])) begin
                    errors++;
                    $display("FAIL full_deq_head dut%0d step%0d got pc=%h inst=%h c=%0d want %h %h %0d",
                             k, i, w_dpc[k], w_dinst[k], w_cnt[k], exp_pc(k), exp_inst(k), m_cnt[k]);
                end
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        deq_stall = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (w_cnt[1] !== 4'd3) begin
            errors++;
            $display("FAIL redir_pre_count got %0d want 3", w_cnt[1]);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (w_cnt[k] !== 4'd0 || w_valid[k] !== 1'b0 || w_addr[k] !== 32'h40) begin
                errors++;
                $display("FAIL redir_flush dut%0d got c=%0d v=%0b a=%h want 0 0 00000040", k, w_cnt[k], w_valid[k], w_addr[k]);
            end
        end
        deq_stall = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (w_valid[k] !== 1'b1 || w_dpc[k] !== 32'h40 || w_dinst[k] !== imem_f(32'h40) || w_dpc4[k] !== 32'h44) begin
                errors++;
                $display("FAIL redir_target dut%0d got v=%0b pc=%h inst=%h pc4=%h want 1 00000040 %h 00000044",
                         k, w_valid[k], w_dpc[k], w_dinst[k], w_dpc4[k], imem_f(32'h40));
            end
        end
    endtask

    task automatic test_redirect_full();
        deq_stall = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_8000;
        tick();
        redirect  = 1'b0;
        deq_stall = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (w_valid[k] !== (m_cnt[k] > 0) || w_dpc[k] !== exp_pc(k) ||
                    (w_valid[k] && w_dpc[k] < 32'h0000_8000)) begin
                    errors++;
                    $display("FAIL redir_full_stale dut%0d cyc%0d got v=%0b pc=%h want %0b %h",
                             k, i, w_valid[k], w_dpc[k], m_cnt[k] > 0, exp_pc(k));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        deq_stall   = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (w_valid[k] !== 1'b1 || w_dpc[k] !== 32'h300) begin
                errors++;
                $display("FAIL b2b_redirect dut%0d got v=%0b pc=%h want 1 00000300", k, w_valid[k], w_dpc[k]);
            end
        end
        tick();
        checks++;
        if (w_dpc[1] !== 32'h304) begin
            errors++;
            $display("FAIL b2b_next got %h want 00000304", w_dpc[1]);
        end
    endtask

    task automatic test_async_rst();
        deq_stall = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        #3;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (w_valid[k] !== 1'b0 || w_addr[k] !== pcr[k] || w_cnt[k] !== 4'd0) begin
                errors++;
                $display("FAIL async_rst dut%0d got v=%0b a=%h c=%0d want 0 %h 0", k, w_valid[k], w_addr[k], w_cnt[k], pcr[k]);
            end
        end
        #1;
        rst = 1'b0;
        model_reset();
        test_stream(6);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            deq_stall = ($urandom_range(0, 9) < 4);
            redirect  = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 2))
                0:       redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                1:       redirect_pc = $urandom;
                default: redirect_pc = {$urandom, 2'b00} & 32'h0000_FFFC;
            endcase
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (w_valid[k] !== (m_cnt[k] > 0) || w_cnt[k] !== 4'(m_cnt[k]) || w_addr[k] !== exp_addr(k)) begin
                    errors++;
                    $display("FAIL rand_state dut%0d cyc%0d got v=%0b c=%0d a=%h want %0b %0d %h",
                             k, i, w_valid[k], w_cnt[k], w_addr[k], m_cnt[k] > 0, m_cnt[k], exp_addr(k));
                end
                checks++;
                if (w_dpc[k] !== exp_pc(k) || w_dpc4[k] !== exp_pc4(k) || w_dinst[k] !== exp_inst(k)) begin
                    errors++;
                    $display("FAIL rand_head dut%0d cyc%0d got pc=%h pc4=%h inst=%h want %h %h %h",
                             k, i, w_dpc[k], w_dpc4[k], w_dinst[k], exp_pc(k), exp_pc4(k), exp_inst(k));
                end
            end
        end
        redirect  = 1'b0;
        deq_stall = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        deq_stall   = 1'b0;
        dep[0] = 2;  dep[1] = 4;  dep[2] = 8;
        pcr[0] = 32'h0;  pcr[1] = 32'h0;  pcr[2] = 32'h0000_1000;
        model_reset();

        test_reset();
        test_stream(8);
        test_stall();
        test_full_deq();
        test_redirect();
        test_redirect_full();
        test_back_to_back();
        test_async_rst();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
